// File: rtl/counter_pkg.sv
// Shared encodings for the counter/timer family: expiry modes and run state.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_RELOAD  = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

endpackage

// File: rtl/reload_down_counter_if.sv
// Control and status bundle of reload_down_counter; master drives, slave is the counter.
interface reload_down_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [1:0]       mode;
  logic [WIDTH-1:0] count;
  logic             zero;
  logic             tc;
  logic             done;

  modport master (
    output en, load, load_val, mode,
    input  count, zero, tc, done
  );

  modport slave (
    input  en, load, load_val, mode,
    output count, zero, tc, done
  );
endinterface

// File: rtl/reload_down_counter.sv
// Loadable down counter with WRAP / RELOAD / ONESHOT expiry and a registered
// terminal-count pulse.
module reload_down_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  reload_down_counter_if.slave  bus
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  state_e           state_q, state_d;
  logic             tc_q, tc_d;

  // Next-count decode: load beats expiry beats decrement beats hold.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    state_d  = state_q;
    tc_d     = 1'b0;
    if (bus.load) begin
      count_d  = bus.load_val;
      reload_d = bus.load_val;
      state_d  = ST_RUN;
    end else if (bus.en && state_q == ST_RUN) begin
      if (count_q == '0) begin
        tc_d = 1'b1;
        // Mode only matters here, so a mid-count change affects the next expiry.
        case (mode_e'(bus.mode))
          MODE_RELOAD:  count_d = reload_q;
          MODE_ONESHOT: begin
            count_d = '0;
            state_d = ST_DONE;
          end
          default:      count_d = {WIDTH{1'b1}};
        endcase
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= RST_VAL;
      reload_q <= RST_VAL;
      state_q  <= ST_RUN;
      tc_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      state_q  <= state_d;
      tc_q     <= tc_d;
    end
  end

  assign bus.count = count_q;
  assign bus.zero  = (count_q == '0);
  assign bus.tc    = tc_q;
  assign bus.done  = (state_q == ST_DONE);

endmodule
